product_bcd_display: RTL and testbench

//  Downstream stage of the 8x8 sequential multiplier. It captures the 16-bit product when done_flag

---
 rtl/mult_pkg.sv | 27 ++
 rtl/bcd_to_seg.sv | 14 +
 rtl/product_bcd_display.sv | 161 ++++++++++++++++
 tb/tb_product_bcd_display.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared encodings, segment codes and double-dabble helper
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'h00;

  // {dp,g,f,e,d,c,b,a} codes for digits 9 down to 0
  localparam logic [9:0][7:0] SEG_CODE = {
    8'h6F, 8'h7F, 8'h07, 8'h7D, 8'h6D,
    8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

  function automatic logic [19:0] dd_adjust(input logic [19:0] a);
    logic [19:0] r;
    r = a;
    for (int i = 0; i < 5; i++) begin
      if (a[4*i +: 4] >= 4'd5) r[4*i +: 4] = a[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// rtl/bcd_to_seg.sv - combinational BCD nibble to 7-segment decoder
module bcd_to_seg
  import mult_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (nib < 4'd10) seg = SEG_CODE[nib];
  end

endmodule

// File: rtl/product_bcd_display.sv
// rtl/product_bcd_display.sv - captures product, converts to BCD, scans a 5-digit display
module product_bcd_display
  import mult_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        done_flag,
  input  logic [15:0] d_in,
  output logic        busy,
  output logic        valid,
  output logic [19:0] bcd,
  output logic [7:0]  seg_data,
  output logic [4:0]  digit_en
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

  state_t      state_q, state_d;
  logic        done_q;
  logic [15:0] bin_sh_q, bin_sh_d;
  logic [19:0] acc_q, acc_d, acc_adj;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic        pending_q, pending_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;
  logic [19:0] bcd_q, bcd_d;
  logic        rise;

  logic [CW-1:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]    digit_idx_q, digit_idx_d;
  logic [4:0]    digit_en_q, digit_en_d;
  logic [7:0]    seg_data_q, seg_data_d;
  logic [3:0]    seg_nib;
  logic [7:0]    seg_dec;
  logic [19:0]   upper;
  logic          blank;

  assign rise    = done_flag & ~done_q;
  assign acc_adj = dd_adjust(acc_q);

  always_comb begin
    state_d   = state_q;
    bin_sh_d  = bin_sh_q;
    acc_d     = acc_q;
    bit_cnt_d = bit_cnt_q;
    pending_d = pending_q;
    bcd_d     = bcd_q;
    valid_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d   = ST_SHIFT;
          bin_sh_d  = d_in;
          acc_d     = '0;
          bit_cnt_d = '0;
        end
      end
      ST_SHIFT: begin
        acc_d     = {acc_adj[18:0], bin_sh_q[15]};
        bin_sh_d  = {bin_sh_q[14:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (rise) pending_d = 1'b1;
        if (bit_cnt_q == 4'd15) state_d = ST_DONE;
      end
      ST_DONE: begin
        bcd_d   = acc_q;
        valid_d = 1'b1;
        // a rise landing on the DONE cycle restarts just like a queued one
        if (pending_q || rise) begin
          state_d   = ST_SHIFT;
          pending_d = 1'b0;
          bin_sh_d  = d_in;
          acc_d     = '0;
          bit_cnt_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE) || valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      done_q    <= 1'b0;
      bin_sh_q  <= '0;
      acc_q     <= '0;
      bit_cnt_q <= '0;
      pending_q <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      bcd_q     <= '0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_flag;
      bin_sh_q  <= bin_sh_d;
      acc_q     <= acc_d;
      bit_cnt_q <= bit_cnt_d;
      pending_q <= pending_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      bcd_q     <= bcd_d;
    end
  end

  always_comb begin
    scan_cnt_d  = scan_cnt_q + CW'(1);
    digit_idx_d = digit_idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d  = '0;
      digit_idx_d = (digit_idx_q == 3'd4) ? 3'd0 : digit_idx_q + 3'd1;
    end
    digit_en_d = 5'b00001 << digit_idx_d;
    case (digit_idx_d)
      3'd1:    seg_nib = bcd_q[7:4];
      3'd2:    seg_nib = bcd_q[11:8];
      3'd3:    seg_nib = bcd_q[15:12];
      3'd4:    seg_nib = bcd_q[19:16];
      default: seg_nib = bcd_q[3:0];
    endcase
  end

  bcd_to_seg u_seg (
    .nib (seg_nib),
    .seg (seg_dec)
  );

  // a digit is blank when it and every more significant digit are zero
  always_comb begin
    upper      = bcd_q >> {digit_idx_d, 2'b00};
    blank      = BLANK_LZ && (digit_idx_d != 3'd0) && (upper == 20'd0);
    seg_data_d = blank ? SEG_BLANK : seg_dec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q  <= '0;
      digit_idx_q <= '0;
      digit_en_q  <= 5'b00001;
      seg_data_q  <= 8'h3F;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      digit_idx_q <= digit_idx_d;
      digit_en_q  <= digit_en_d;
      seg_data_q  <= seg_data_d;
    end
  end

  assign busy     = busy_q;
  assign valid    = valid_q;
  assign bcd      = bcd_q;
  assign seg_data = seg_data_q;
  assign digit_en = digit_en_q;

endmodule

// File: tb/tb_product_bcd_display.sv
// tb/tb_product_bcd_display.sv - directed self-checking bench for product_bcd_display
module tb_product_bcd_display;

  logic        clk = 1'b0;
  logic        rst;
  logic        done_flag;
  logic [15:0] d_in;
  logic        busy, valid, busy_nb, valid_nb;
  logic [19:0] bcd, bcd_nb;
  logic [7:0]  seg_data, seg_data_nb;
  logic [4:0]  digit_en, digit_en_nb;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  product_bcd_display #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .done_flag(done_flag), .d_in(d_in),
    .busy(busy), .valid(valid), .bcd(bcd), .seg_data(seg_data), .digit_en(digit_en)
  );

  product_bcd_display #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .done_flag(done_flag), .d_in(d_in),
    .busy(busy_nb), .valid(valid_nb), .bcd(bcd_nb), .seg_data(seg_data_nb), .digit_en(digit_en_nb)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic convert(input logic [15:0] val, input logic [19:0] exp_bcd);
    int n;
    bit busy_ok;
    d_in = val;
    done_flag = 1'b1;
    tick();
    check("busy_start", busy, 1);
    done_flag = 1'b0;
    n = 0;
    busy_ok = 1'b1;
    while (n < 40) begin
      tick();
      n++;
      if (valid) break;
      if (!busy) busy_ok = 1'b0;
    end
    check("latency", n, 17);
    check("busy_during", busy_ok, 1);
    check("busy_at_valid", busy, 1);
    check("bcd", bcd, exp_bcd);
    tick();
    check("valid_one_cycle", valid, 0);
    check("busy_end", busy, 0);
  endtask

  // expected segment bytes packed {d4,d3,d2,d1,d0}
  task automatic disp(input string tag, input logic [39:0] exp_lz, input logic [39:0] exp_all);
    int idx;
    repeat (20) begin
      tick();
      idx = -1;
      for (int i = 0; i < 5; i++) if (digit_en == (5'b00001 << i)) idx = i;
      check({tag, "_onehot"}, (idx >= 0), 1);
      if (idx >= 0) begin
        check({tag, "_seg_lz"}, seg_data, exp_lz[8*idx +: 8]);
        check({tag, "_seg_all"}, seg_data_nb, exp_all[8*idx +: 8]);
      end
    end
  endtask

  initial begin
    int vcount;
    rst = 1'b1;
    done_flag = 1'b0;
    d_in = 16'd0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_bcd", bcd, 0);
    check("rst_en", digit_en, 5'b00001);
    check("rst_seg", seg_data, 8'h3F);
    rst = 1'b0;

    for (int i = 1; i <= 25; i++) begin
      tick();
      check("scan_en", digit_en, 32'(1) << ((i / 4) % 5));
      check("scan_seg_lz", seg_data, ((i / 4) % 5 == 0) ? 8'h3F : 8'h00);
      check("scan_seg_all", seg_data_nb, 8'h3F);
    end

    convert(16'd65025, 20'h65025);
    disp("max", {8'h7D, 8'h6D, 8'h3F, 8'h5B, 8'h6D}, {8'h7D, 8'h6D, 8'h3F, 8'h5B, 8'h6D});

    convert(16'd0, 20'h00000);
    disp("zero", {8'h00, 8'h00, 8'h00, 8'h00, 8'h3F}, {8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F});

    convert(16'd100, 20'h00100);
    disp("hundred", {8'h00, 8'h00, 8'h06, 8'h3F, 8'h3F}, {8'h3F, 8'h3F, 8'h06, 8'h3F, 8'h3F});

    d_in = 16'd1234;
    done_flag = 1'b1;
    tick();
    done_flag = 1'b0;
    repeat (4) tick();
    done_flag = 1'b1;
    tick();
    done_flag = 1'b0;
    repeat (11) tick();
    d_in = 16'd42;
    tick();
    check("pend_valid1", valid, 1);
    check("pend_bcd1", bcd, 20'h01234);
    repeat (16) tick();
    check("pend_busy_mid", busy, 1);
    check("pend_no_valid", valid, 0);
    tick();
    check("pend_valid2", valid, 1);
    check("pend_bcd2", bcd, 20'h00042);
    tick();
    check("pend_idle", busy, 0);

    d_in = 16'd999;
    done_flag = 1'b1;
    tick();
    done_flag = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_bcd", bcd, 0);
    check("abort_en", digit_en, 5'b00001);
    check("abort_seg", seg_data, 8'h3F);
    vcount = 0;
    repeat (25) begin
      tick();
      if (valid) vcount++;
    end
    check("abort_no_valid", vcount, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
